// File: rtl/crctab_pkg.sv
// Shared definitions for the CRC lookup-table arbiter: table geometry,
// default requester count and the arbiter FSM state type.
package crctab_pkg;

  localparam int TAB_ADDR_W = 8;
  localparam int TAB_DATA_W = 32;
  localparam int NREQ_DEF   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/crctab_rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// searching circularly upward from rr_ptr, as a one-hot grant and an index.
module crctab_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_req
);

  // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
  localparam int CW = ID_W + 1;

  logic [CW-1:0] cand;

  // Walk the circular order from farthest to nearest so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a value before any branch; otherwise a path that
    // skips an assignment makes synthesis infer a latch.
    gnt     = '0;
    gnt_id  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (req[cand[ID_W-1:0]]) begin
        gnt_id  = cand[ID_W-1:0];
        any_req = 1'b1;
      end
    end
    gnt[gnt_id] = any_req;
  end

endmodule

// File: rtl/crctab_arb.sv
// Arbiter sharing one combinational-read CRC table among NREQ requesters.
// Round-robin between bursts, locked to one owner for the length of a burst,
// one beat per cycle, registered response with 1-cycle latency.
module crctab_arb
  import crctab_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*8-1:0]     req_addr,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [31:0]           tab_addr,
  input  logic [TAB_DATA_W-1:0] tab_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [TAB_DATA_W-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy
);

  arb_state_t            state, state_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_nxt;
  logic [ID_W-1:0]       owner, owner_nxt;
  logic [NREQ-1:0]       owner_mask;
  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  any_req;
  logic                  can_accept;
  logic                  accept;
  logic [TAB_ADDR_W-1:0] sel_addr;
  logic                  sel_last;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // While locked only the burst owner may compete for the table.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    elig              = (state == LOCK) ? (req_valid & owner_mask) : req_valid;
  end

  crctab_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req     (elig),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  // The response register can take a new beat if it is empty or draining now.
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = !rst && any_req && can_accept;
  assign req_ready  = {NREQ{accept}} & gnt;
  assign tab_addr   = accept ? {{(32 - TAB_ADDR_W){1'b0}}, sel_addr} : '0;
  assign busy       = !rst && ((state == LOCK) || rsp_valid);

  // Mux the granted requester's address and last flag with the one-hot grant.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_addr = req_addr[i*8 +: 8];
    end
    sel_last = |(gnt & req_last);
  end

  // Next-state logic: open a burst on a non-last beat, close it on the last.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (sel_last) begin
            rr_nxt = next_id(gnt_id);
          end else begin
            state_nxt = LOCK;
            owner_nxt = gnt_id;
          end
        end
        LOCK: begin
          if (sel_last) begin
            state_nxt = IDLE;
            rr_nxt    = next_id(owner);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before this edge, so the update order inside the block is irrelevant.
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      owner  <= owner_nxt;
    end
  end

  // Response register: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_data  <= tab_rdata;
      rsp_last  <= sel_last;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crctab_arb.sv
// Self-checking bench for crctab_arb: a reference model predicts grants and
// queues expected responses; a separate monitor pops and compares them.
module tb_crctab_arb;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       tab_addr;
  logic [31:0]       tab_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic              busy;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  logic [31:0] tbl [256];
  rsp_t        exp_q[$];
  rsp_t        obs_rsp[$];
  int          obs_gnt[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: locked owner (-1 when idle), search start, response pending.
  int m_owner = -1;
  int m_rr    = 0;
  bit m_valid = 1'b0;

  // Monitor state for the hold-stable check.
  bit              hold_prev = 1'b0;
  logic [ID_W-1:0] prev_id;
  logic [31:0]     prev_data;
  logic            prev_last;

  crctab_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tab_addr  (tab_addr),
    .tab_rdata (tab_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign tab_rdata = tbl[tab_addr[7:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int ref_pick(input logic [NREQ-1:0] v);
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: checks the combinational outputs, then advances one cycle.
  always @(negedge clk) begin
    int              g;
    bit              can;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     exp_taddr;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_gnt.push_back(i);
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_tab_addr", tab_addr, 0);
      check("rst_busy", busy, 0);
      m_owner = -1;
      m_rr    = 0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      can       = !m_valid || rsp_ready;
      g         = ref_pick(req_valid);
      exp_rdy   = '0;
      exp_taddr = '0;
      if (can && g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_taddr  = {24'b0, req_addr[g*8 +: 8]};
      end
      check("req_ready", req_ready, exp_rdy);
      check("tab_addr", tab_addr, exp_taddr);
      check("rsp_valid", rsp_valid, m_valid);
      check("busy", busy, (m_owner >= 0) || m_valid);
      if (can && g >= 0) begin
        exp_q.push_back('{id: g, data: tbl[req_addr[g*8 +: 8]], last: req_last[g]});
        if (req_last[g]) begin
          m_rr    = ((m_owner >= 0 ? m_owner : g) + 1) % NREQ;
          m_owner = -1;
        end else begin
          m_owner = g;
        end
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: stability under backpressure and in-order comparison on each transfer.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid) begin
      if (hold_prev) begin
        check("hold_id", rsp_id, prev_id);
        check("hold_data", rsp_data, prev_data);
        check("hold_last", rsp_last, prev_last);
      end
      if (rsp_ready) begin
        obs_rsp.push_back('{id: int'(rsp_id), data: rsp_data, last: rsp_last});
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_last", rsp_last, e.last);
        end
      end
      hold_prev = !rsp_ready;
      prev_id   = rsp_id;
      prev_data = rsp_data;
      prev_last = rsp_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_last  = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
    obs_gnt.delete();
    obs_rsp.delete();
  endtask

  task automatic check_gnts(input string name, input int n, input int e [8]);
    check($sformatf("%s_count", name), obs_gnt.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_gnt.size()) check($sformatf("%s_%0d", name, i), obs_gnt[i], e[i]);
    end
  endtask

  task automatic check_rsp(input string name, input int idx, input int id,
                           input logic [31:0] data, input logic last);
    check($sformatf("%s_present", name), obs_rsp.size() > idx, 1);
    if (obs_rsp.size() > idx) begin
      check($sformatf("%s_id", name), obs_rsp[idx].id, id);
      check($sformatf("%s_data", name), obs_rsp[idx].data, data);
      check($sformatf("%s_last", name), obs_rsp[idx].last, last);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = (32'(i) * 32'h9e3779b9) ^ 32'h5bd1e995;
    tbl[8'h01] = 32'h8090a067;
    tbl[8'h80] = 32'h7cd643f7;
    tbl[8'hff] = 32'h28ebe287;

    rst = 1'b1;
    idle_inputs();
    step(3);

    // Single beat from requester 0.
    do_reset();
    req_valid = 4'b0001; req_addr[7:0] = 8'h01; req_last = 4'b1111;
    step();
    idle_inputs();
    step(2);
    check_gnts("single", 1, '{0, 0, 0, 0, 0, 0, 0, 0});
    check_rsp("single_rsp", 0, 0, 32'h8090a067, 1'b1);

    // Round robin across all four requesters.
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_addr = 32'h44332211;
    step(5);
    idle_inputs();
    step(2);
    check_gnts("rr", 5, '{0, 1, 2, 3, 0, 0, 0, 0});
    check("rr_rsp_count", obs_rsp.size(), 5);

    // Burst lock: requester 2 holds the table while requester 0 waits.
    do_reset();
    req_valid = 4'b0100; req_addr[23:16] = 8'h80; req_last = 4'b0000;
    step();
    req_valid = 4'b0101; req_addr[23:16] = 8'hff; req_addr[7:0] = 8'h33; req_last = 4'b0101;
    step();
    req_valid = 4'b0001;
    step();
    idle_inputs();
    step(2);
    check_gnts("lock", 3, '{2, 2, 0, 0, 0, 0, 0, 0});
    check_rsp("lock_rsp0", 0, 2, 32'h7cd643f7, 1'b0);
    check_rsp("lock_rsp1", 1, 2, 32'h28ebe287, 1'b1);
    check_rsp("lock_rsp2", 2, 0, tbl[8'h33], 1'b1);

    // Backpressure: three stalled cycles, then drain and accept together.
    do_reset();
    req_valid = 4'b0001; req_addr[7:0] = 8'h01; req_last = 4'b1111;
    step();
    rsp_ready = 1'b0; req_valid = 4'b0010; req_addr[15:8] = 8'h02;
    step(3);
    check("bp_no_grant_stalled", obs_gnt.size(), 1);
    rsp_ready = 1'b1;
    step();
    idle_inputs();
    step(2);
    check_gnts("bp", 2, '{0, 1, 0, 0, 0, 0, 0, 0});
    check_rsp("bp_rsp1", 1, 1, tbl[8'h02], 1'b1);

    // Reset mid-burst with a response pending.
    do_reset();
    req_valid = 4'b0010; req_addr[15:8] = 8'h80; req_last = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 4'b1010; req_last = 4'b1111;
    obs_gnt.delete();
    @(negedge clk);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_busy", busy, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    step(2);
    check_gnts("rstmid", 1, '{1, 0, 0, 0, 0, 0, 0, 0});

    // Pointer wrap from requester 3 back to 0.
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1111;
    step();
    req_valid = 4'b1001;
    step();
    idle_inputs();
    step(2);
    check_gnts("wrap", 2, '{3, 0, 0, 0, 0, 0, 0, 0});

    // Randomised traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = NREQ'($urandom);
      req_addr  = $urandom;
      req_last  = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
